// File: rtl/ifid_latch_if.sv
// ifid_latch_if: fetch-side inputs, hazard controls and decode-side outputs of the IF/ID latch
interface ifid_latch_if;
  logic [15:0] IF_Instr;
  logic [15:0] IF_PC_Next;
  logic        IF_Valid;
  logic        IF_err;
  logic        stall;
  logic        flush;
  logic [15:0] IFID_Instr;
  logic [15:0] IFID_PC_Next;
  logic        IFID_err;
  logic        IFID_NOP;
  logic        IFID_Halt;
  logic        PC_Hold;
  modport master (
    output IF_Instr, IF_PC_Next, IF_Valid, IF_err, stall, flush,
    input  IFID_Instr, IFID_PC_Next, IFID_err, IFID_NOP, IFID_Halt, PC_Hold
  );
  modport slave (
    input  IF_Instr, IF_PC_Next, IF_Valid, IF_err, stall, flush,
    output IFID_Instr, IFID_PC_Next, IFID_err, IFID_NOP, IFID_Halt, PC_Hold
  );
endinterface

// File: rtl/ifid_latch.sv
// ifid_latch: IF/ID pipeline register with one-entry skid buffer and sticky halt
module ifid_latch (
  input logic          clk,
  input logic          rst,
  ifid_latch_if.slave  bus
);
  typedef enum logic [1:0] {RUN, SKID, HALTED} state_t;
  localparam logic [15:0] BUBBLE = 16'h0800;
  state_t      state_q, state_d;
  logic [15:0] instr_q, instr_d, pc_q, pc_d, sk_instr_q, sk_instr_d, sk_pc_q, sk_pc_d;
  logic        err_q, err_d, nop_q, nop_d, sk_err_q, sk_err_d, load;
  always_comb begin
    state_d    = state_q;
    instr_d    = instr_q;
    pc_d       = pc_q;
    err_d      = err_q;
    nop_d      = nop_q;
    sk_instr_d = sk_instr_q;
    sk_pc_d    = sk_pc_q;
    sk_err_d   = sk_err_q;
    load       = 1'b0;
    if (bus.flush) begin
      state_d    = RUN;
      instr_d    = BUBBLE;
      pc_d       = 16'h0000;
      err_d      = 1'b0;
      nop_d      = 1'b1;
      sk_instr_d = 16'h0000;
      sk_pc_d    = 16'h0000;
      sk_err_d   = 1'b0;
    end else if (bus.stall) begin
      if (state_q == RUN && bus.IF_Valid) begin
        sk_instr_d = bus.IF_Instr;
        sk_pc_d    = bus.IF_PC_Next;
        sk_err_d   = bus.IF_err;
        state_d    = SKID;
      end
    end else begin
      // skid drains ahead of IF; a halted core only ever emits bubbles
      load    = state_q == SKID || (state_q == RUN && bus.IF_Valid);
      instr_d = !load ? BUBBLE : state_q == SKID ? sk_instr_q : bus.IF_Instr;
      pc_d    = !load ? 16'h0000 : state_q == SKID ? sk_pc_q : bus.IF_PC_Next;
      err_d   = load && (state_q == SKID ? sk_err_q : bus.IF_err);
      nop_d   = !load;
      state_d = (load && instr_d[15:11] == 5'b00000) || state_q == HALTED ? HALTED : RUN;
    end
  end
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q    <= RUN;
      instr_q    <= BUBBLE;
      pc_q       <= 16'h0000;
      err_q      <= 1'b0;
      nop_q      <= 1'b1;
      sk_instr_q <= 16'h0000;
      sk_pc_q    <= 16'h0000;
      sk_err_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      instr_q    <= instr_d;
      pc_q       <= pc_d;
      err_q      <= err_d;
      nop_q      <= nop_d;
      sk_instr_q <= sk_instr_d;
      sk_pc_q    <= sk_pc_d;
      sk_err_q   <= sk_err_d;
    end
  end
  assign bus.IFID_Instr   = instr_q;
  assign bus.IFID_PC_Next = pc_q;
  assign bus.IFID_err     = err_q;
  assign bus.IFID_NOP     = nop_q;
  assign bus.IFID_Halt    = !nop_q && instr_q[15:11] == 5'b00000;
  assign bus.PC_Hold      = state_q != RUN;
endmodule
